// File: rtl/cnn_serial_stream_bridge.sv
// cnn_serial_stream_bridge
// Host-side bridge to the CNN accelerator's serial byte interface.
//  TX: 32-bit command words are sent LSB byte first on the weight or line
//      channel, one valid strobe per byte, optional idle gap after each byte.
//  RX: result bytes are packed into 32-bit words and queued in a small FIFO.
// Ports:
//  clk, reset_n                        clock, async active-low reset
//  cmd_valid/cmd_ready/cmd_sel/
//  cmd_bytes/cmd_data                  command word handshake
//  serial_weight_data/valid            weight channel byte stream
//  serial_line_data/valid              line channel byte stream
//  serial_result/serial_result_valid   result byte stream from the core
//  flush                               push the partially packed word
//  res_valid/res_ready/res_data/
//  res_count                           result FIFO head and pop handshake
//  overflow/overflow_clr               sticky drop flag and its clear
//  busy                                TX engine active
// Optional feature: define CNN_STREAM_AUTOFLUSH_EN to flush a partial result
// word automatically after FLUSH_TIMEOUT idle cycles.
module cnn_serial_stream_bridge #(
   parameter int unsigned RES_FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES     = 0,
   parameter int unsigned FLUSH_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_sel,
   input  logic [2:0]  cmd_bytes,
   input  logic [31:0] cmd_data,
   output logic [7:0]  serial_weight_data,
   output logic        serial_weight_valid,
   output logic [7:0]  serial_line_data,
   output logic        serial_line_valid,
   input  logic [7:0]  serial_result,
   input  logic        serial_result_valid,
   input  logic        flush,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [2:0]  res_count,
   output logic        overflow,
   input  logic        overflow_clr,
   output logic        busy
);

   localparam int unsigned PTR_W = $clog2(RES_FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   // Elaboration-time parameter sanity checks
   if (RES_FIFO_DEPTH < 2 || (RES_FIFO_DEPTH & (RES_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("RES_FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (GAP_CYCLES > 15) begin : g_bad_gap
      $error("GAP_CYCLES must be in 0..15");
   end
   if (FLUSH_TIMEOUT < 1) begin : g_bad_timeout
      $error("FLUSH_TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} tx_state_e;

   // ---------------- TX engine ----------------
   tx_state_e   state_q, state_d;
   logic [1:0]  idx_q, idx_d, last_q, last_d;
   logic        sel_q, sel_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  gap_q, gap_d;
   logic [7:0]  wdata_q, wdata_d, ldata_q, ldata_d, tx_byte;
   logic        wvalid_q, wvalid_d, lvalid_q, lvalid_d;
   logic        ready_q, ready_d, busy_q, busy_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         last_q   <= '0;
         sel_q    <= 1'b0;
         data_q   <= '0;
         gap_q    <= '0;
         wdata_q  <= '0;
         wvalid_q <= 1'b0;
         ldata_q  <= '0;
         lvalid_q <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
         data_q   <= data_d;
         gap_q    <= gap_d;
         wdata_q  <= wdata_d;
         wvalid_q <= wvalid_d;
         ldata_q  <= ldata_d;
         lvalid_q <= lvalid_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   // Next state; channel outputs are registered copies of the next-state decode
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      sel_d   = sel_q;
      data_d  = data_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d = S_SEND;
               idx_d   = 2'd0;
               sel_d   = cmd_sel;
               data_d  = cmd_data;
               // 0 and 5..7 all mean a full 4-byte word
               last_d  = (cmd_bytes >= 3'd1 && cmd_bytes <= 3'd3) ? 2'(cmd_bytes - 3'd1) : 2'd3;
            end
         end
         S_SEND: begin
            if (GAP_CYCLES != 0) begin
               state_d = S_GAP;
               gap_d   = 4'(GAP_CYCLES - 1);
            end else if (idx_q == last_q) begin
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         S_GAP: begin
            if (gap_q != 4'd0) begin
               gap_d = gap_q - 4'd1;
            end else if (idx_q == last_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_SEND;
               idx_d   = idx_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      tx_byte  = 8'(data_d >> {idx_d, 3'b000});
      wvalid_d = (state_d == S_SEND) && !sel_d;
      lvalid_d = (state_d == S_SEND) && sel_d;
      wdata_d  = wvalid_d ? tx_byte : 8'd0;
      ldata_d  = lvalid_d ? tx_byte : 8'd0;
      ready_d  = (state_d == S_IDLE);
      busy_d   = (state_d != S_IDLE);
   end

   // ---------------- RX packer ----------------
   logic [31:0] pack_q, pack_d, pack_ins;
   logic [1:0]  p_q, p_d;
   logic [2:0]  p_ins;
   logic        auto_flush_c, push_c;

`ifdef CNN_STREAM_AUTOFLUSH_EN
   localparam int unsigned TO_W = $clog2(FLUSH_TIMEOUT + 1);
   logic [TO_W-1:0] idle_q, idle_d;

   // Counts idle cycles while a partial word is held; fires on the last one
   always_comb begin
      auto_flush_c = !serial_result_valid && (p_q != 2'd0) && (idle_q == TO_W'(FLUSH_TIMEOUT - 1));
      idle_d       = (serial_result_valid || p_q == 2'd0 || auto_flush_c) ? '0 : idle_q + TO_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) idle_q <= '0;
      else          idle_q <= idle_d;
   end
`else
   assign auto_flush_c = 1'b0;
`endif

   // Byte is inserted first so a same-cycle flush carries it
   always_comb begin
      pack_ins = pack_q;
      p_ins    = {1'b0, p_q};
      if (serial_result_valid) begin
         pack_ins = pack_q | (32'(serial_result) << {p_q, 3'b000});
         p_ins    = {1'b0, p_q} + 3'd1;
      end
      push_c = (p_ins == 3'd4) || ((flush || auto_flush_c) && p_ins != 3'd0);
      pack_d = push_c ? 32'd0 : pack_ins;
      p_d    = push_c ? 2'd0  : p_ins[1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pack_q <= '0;
         p_q    <= '0;
      end else begin
         pack_q <= pack_d;
         p_q    <= p_d;
      end
   end

   // ---------------- Result FIFO ----------------
   logic [31:0]      mem_data_q [RES_FIFO_DEPTH];
   logic [2:0]       mem_cnt_q  [RES_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_c, pop_c, push_ok_c, drop_c;
   logic             rvalid_q, rvalid_d, ovf_q, ovf_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [2:0]       rcount_q, rcount_d;

   // Head word is registered; bypass when the new read slot is written now
   always_comb begin
      full_c    = (level_q == LVL_W'(RES_FIFO_DEPTH));
      pop_c     = rvalid_q && res_ready;
      push_ok_c = push_c && (!full_c || pop_c);
      drop_c    = push_c && full_c && !pop_c;
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_c);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_c);
      level_d   = level_q + LVL_W'(push_ok_c) - LVL_W'(pop_c);
      rvalid_d  = (level_d != '0);
      rdata_d   = 32'd0;
      rcount_d  = 3'd0;
      if (rvalid_d) begin
         if (push_ok_c && rd_ptr_d == wr_ptr_q) begin
            rdata_d  = pack_ins;
            rcount_d = p_ins;
         end else begin
            rdata_d  = mem_data_q[rd_ptr_d];
            rcount_d = mem_cnt_q[rd_ptr_d];
         end
      end
      ovf_d = drop_c ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem_data_q[wr_ptr_q] <= pack_ins;
         mem_cnt_q[wr_ptr_q]  <= p_ins;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rcount_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rcount_q <= rcount_d;
         ovf_q    <= ovf_d;
      end
   end

   assign cmd_ready           = ready_q;
   assign busy                = busy_q;
   assign serial_weight_data  = wdata_q;
   assign serial_weight_valid = wvalid_q;
   assign serial_line_data    = ldata_q;
   assign serial_line_valid   = lvalid_q;
   assign res_valid           = rvalid_q;
   assign res_data            = rdata_q;
   assign res_count           = rcount_q;
   assign overflow            = ovf_q;

endmodule

// File: tb/tb_cnn_serial_stream_bridge.sv
// Scoreboard bench for cnn_serial_stream_bridge: one instance with no byte
// gap, one with a 2-cycle gap used for the line-channel gap sequences.
module tb_cnn_serial_stream_bridge;

   localparam int unsigned GAP_B = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_valid_g, cmd_sel;
   logic [2:0]  cmd_bytes;
   logic [31:0] cmd_data;
   logic [7:0]  serial_result;
   logic        serial_result_valid, flush, res_ready, overflow_clr;

   logic        cmd_ready, busy, wv, lv, res_valid, overflow;
   logic [7:0]  wd, ld;
   logic [31:0] res_data;
   logic [2:0]  res_count;

   logic        g_cmd_ready, g_busy, g_wv, g_lv, g_res_valid, g_overflow;
   logic [7:0]  g_wd, g_ld;
   logic [31:0] g_res_data;
   logic [2:0]  g_res_count;

   always #5 clk = ~clk;

   cnn_serial_stream_bridge #(.RES_FIFO_DEPTH(4), .GAP_CYCLES(0), .FLUSH_TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
      .cmd_bytes(cmd_bytes), .cmd_data(cmd_data),
      .serial_weight_data(wd), .serial_weight_valid(wv),
      .serial_line_data(ld), .serial_line_valid(lv),
      .serial_result(serial_result), .serial_result_valid(serial_result_valid),
      .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_count(res_count),
      .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy));

   cnn_serial_stream_bridge #(.RES_FIFO_DEPTH(4), .GAP_CYCLES(GAP_B), .FLUSH_TIMEOUT(16)) dut_g (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid_g), .cmd_ready(g_cmd_ready), .cmd_sel(cmd_sel),
      .cmd_bytes(cmd_bytes), .cmd_data(cmd_data),
      .serial_weight_data(g_wd), .serial_weight_valid(g_wv),
      .serial_line_data(g_ld), .serial_line_valid(g_lv),
      .serial_result(8'h00), .serial_result_valid(1'b0),
      .flush(1'b0), .res_valid(g_res_valid), .res_ready(1'b0),
      .res_data(g_res_data), .res_count(g_res_count),
      .overflow(g_overflow), .overflow_clr(1'b0), .busy(g_busy));

   typedef struct packed {logic [7:0] d; logic [31:0] c;} byte_exp_t;
   typedef struct packed {logic [31:0] w; logic [2:0] n;} word_exp_t;

   byte_exp_t wq[$], lq[$], gq[$];
   word_exp_t rq[$];
   byte_exp_t be;
   word_exp_t we;

   int          n_chk  = 0;
   int          n_fail = 0;
   int unsigned cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   // Monitor: compare each presented byte/word against the scoreboard
   always @(negedge clk) begin
      if (reset_n) begin
         if (wv) begin
            if (wq.size() == 0) fail_now("weight_unexpected");
            else begin
               be = wq.pop_front();
               chk("weight_data", 40'(wd), 40'(be.d));
               chk("weight_cycle", 40'(cyc), 40'(be.c));
            end
         end else chk("weight_idle_zero", 40'(wd), 40'd0);
         if (lv) begin
            if (lq.size() == 0) fail_now("line_unexpected");
            else begin
               be = lq.pop_front();
               chk("line_data", 40'(ld), 40'(be.d));
               chk("line_cycle", 40'(cyc), 40'(be.c));
            end
         end else chk("line_idle_zero", 40'(ld), 40'd0);
         if (g_lv) begin
            if (gq.size() == 0) fail_now("gap_line_unexpected");
            else begin
               be = gq.pop_front();
               chk("gap_line_data", 40'(g_ld), 40'(be.d));
               chk("gap_line_cycle", 40'(cyc), 40'(be.c));
            end
         end else chk("gap_line_idle_zero", 40'(g_ld), 40'd0);
         chk("gap_weight_quiet", 40'({g_wv, g_wd}), 40'd0);
         if (res_valid && res_ready) begin
            if (rq.size() == 0) fail_now("result_unexpected");
            else begin
               we = rq.pop_front();
               chk("result_word", 40'({res_data, res_count}), 40'({we.w, we.n}));
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one command; n_exp is the hand-derived number of bytes on the wire
   task automatic send(input bit g, input bit sel, input logic [2:0] nb,
                       input logic [31:0] d, input int n_exp, output int unsigned h);
      int unsigned gap = g ? GAP_B : 0;
      int budget = 0;
      cmd_sel   = sel;
      cmd_bytes = nb;
      cmd_data  = d;
      if (g) cmd_valid_g = 1'b1; else cmd_valid = 1'b1;
      while (!(g ? g_cmd_ready : cmd_ready) && budget < 50) begin
         tick();
         budget++;
      end
      if (budget >= 50) fail_now("cmd_ready_timeout");
      tick();
      h = cyc;
      cmd_valid   = 1'b0;
      cmd_valid_g = 1'b0;
      for (int k = 0; k < n_exp; k++) begin
         be.d = 8'(d >> (8 * k));
         be.c = h + k * (1 + gap);
         if (g) gq.push_back(be);
         else if (sel) lq.push_back(be);
         else wq.push_back(be);
      end
   endtask

   task automatic rbyte(input logic [7:0] b, input logic fl);
      serial_result       = b;
      serial_result_valid = 1'b1;
      flush               = fl;
      tick();
      serial_result_valid = 1'b0;
      serial_result       = 8'h00;
      flush               = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic exp_word(input logic [31:0] w, input logic [2:0] n);
      word_exp_t e;
      e.w = w;
      e.n = n;
      rq.push_back(e);
   endtask

   task automatic push_words(input int first, input int last_w);
      for (int w = first; w <= last_w; w++)
         for (int j = 0; j < 4; j++) rbyte(8'(w * 16 + j), 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned h;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_valid_g = 1'b0; cmd_sel = 1'b0;
      cmd_bytes = 3'd0; cmd_data = 32'd0; serial_result = 8'd0;
      serial_result_valid = 1'b0; flush = 1'b0; res_ready = 1'b0; overflow_clr = 1'b0;
      tick(3);
      chk("reset_cmd_ready", 40'(cmd_ready), 40'd1);
      chk("reset_outputs", 40'({busy, wv, wd, lv, ld, res_valid, overflow, res_count}), 40'd0);
      chk("reset_res_data", 40'(res_data), 40'd0);
      reset_n = 1'b1;
      tick(2);

      // Weight send, 4 bytes, no gap
      send(1'b0, 1'b0, 3'd4, 32'hA1B2C3D4, 4, h);
      tick(3);
      chk("ready_low_last_byte", 40'({cmd_ready, busy}), 40'b01);
      tick();
      chk("ready_back_5th_cycle", 40'({cmd_ready, busy}), 40'b10);
      send(1'b0, 1'b0, 3'd3, 32'h11CCBBAA, 3, h);
      send(1'b0, 1'b1, 3'd0, 32'hDEADBEEF, 4, h);
      send(1'b0, 1'b1, 3'd7, 32'h04030201, 4, h);
      send(1'b0, 1'b0, 3'd1, 32'h000000E7, 1, h);
      tick(6);

      // Line send with 2-cycle gap
      send(1'b1, 1'b1, 3'd2, 32'h00001234, 2, h);
      tick(5);
      chk("gap_ready_low", 40'({g_cmd_ready, g_busy}), 40'b01);
      tick();
      chk("gap_ready_back", 40'({g_cmd_ready, g_busy}), 40'b10);
      send(1'b1, 1'b1, 3'd0, 32'h89ABCDEF, 4, h);
      tick(14);
      chk("gap_idle_after_4", 40'(g_busy), 40'd0);

      // Result packing and flush
      res_ready = 1'b1;
      exp_word(32'h44332211, 3'd4);
      exp_word(32'h00000055, 3'd1);
      rbyte(8'h11, 1'b0); rbyte(8'h22, 1'b0); rbyte(8'h33, 1'b0);
      rbyte(8'h44, 1'b0); rbyte(8'h55, 1'b0);
      do_flush();
      tick(3);
      do_flush();
      tick(3);
      chk("flush_empty_no_push", 40'({res_valid, 32'(rq.size())}), 40'd0);
      exp_word(32'h00887766, 3'd3);
      rbyte(8'h66, 1'b0); rbyte(8'h77, 1'b0); rbyte(8'h88, 1'b1);
      exp_word(32'h4D3C2B1A, 3'd4);
      rbyte(8'h1A, 1'b0); rbyte(8'h2B, 1'b0); rbyte(8'h3C, 1'b0); rbyte(8'h4D, 1'b1);
      tick(3);
      chk("flush_same_cycle_done", 40'(rq.size()), 40'd0);

      // Overflow: 5 words into depth 4
      res_ready = 1'b0;
      exp_word(32'h13121110, 3'd4);
      exp_word(32'h23222120, 3'd4);
      exp_word(32'h33323130, 3'd4);
      exp_word(32'h43424140, 3'd4);
      push_words(1, 5);
      chk("overflow_set", 40'({overflow, res_valid}), 40'b11);
      tick(3);
      chk("overflow_sticky", 40'(overflow), 40'd1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      chk("overflow_cleared", 40'(overflow), 40'd0);
      rbyte(8'h70, 1'b0); rbyte(8'h71, 1'b0); rbyte(8'h72, 1'b0);
      overflow_clr = 1'b1;
      rbyte(8'h73, 1'b0);
      overflow_clr = 1'b0;
      chk("overflow_set_beats_clr", 40'(overflow), 40'd1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      res_ready = 1'b1;
      tick(6);
      res_ready = 1'b0;
      chk("overflow_drain", 40'({res_valid, overflow, 32'(rq.size())}), 40'd0);

      // Push and pop in the same cycle while full
      exp_word(32'h83828180, 3'd4);
      exp_word(32'h93929190, 3'd4);
      exp_word(32'hA3A2A1A0, 3'd4);
      exp_word(32'hB3B2B1B0, 3'd4);
      exp_word(32'hC3C2C1C0, 3'd4);
      push_words(8, 11);
      rbyte(8'hC0, 1'b0); rbyte(8'hC1, 1'b0); rbyte(8'hC2, 1'b0);
      res_ready = 1'b1;
      rbyte(8'hC3, 1'b0);
      res_ready = 1'b0;
      chk("full_push_pop_no_ovf", 40'({overflow, res_valid}), 40'b01);
      chk("full_push_pop_remaining", 40'(rq.size()), 40'd4);
      res_ready = 1'b1;
      tick(6);
      chk("full_push_pop_drain", 40'({res_valid, 32'(rq.size())}), 40'd0);

      // Reset in the middle of a transfer with a partial result word
      rbyte(8'hE1, 1'b0); rbyte(8'hE2, 1'b0);
      send(1'b0, 1'b0, 3'd4, 32'h0F0E0D0C, 4, h);
      tick(2);
      wq.delete();
      reset_n = 1'b0;
      #1;
      chk("reset_mid_valids", 40'({wv, lv, wd, ld}), 40'd0);
      chk("reset_mid_ready", 40'({cmd_ready, busy, res_valid, overflow}), 40'b1000);
      tick(2);
      reset_n = 1'b1;
      tick();
      chk("reset_release_idle", 40'({cmd_ready, busy, res_valid}), 40'b100);
      exp_word(32'hA3A2A1A0, 3'd4);
      rbyte(8'hA0, 1'b0); rbyte(8'hA1, 1'b0); rbyte(8'hA2, 1'b0); rbyte(8'hA3, 1'b0);
      tick(3);
      chk("reset_slot0_word", 40'(rq.size()), 40'd0);

      // Idle partial word: auto-flushed only when the feature is built in
      rbyte(8'h31, 1'b0); rbyte(8'h32, 1'b0); rbyte(8'h33, 1'b0);
`ifdef CNN_STREAM_AUTOFLUSH_EN
      exp_word(32'h00333231, 3'd3);
      tick(20);
      chk("autoflush_word", 40'({res_valid, 32'(rq.size())}), 40'd0);
`else
      tick(20);
      chk("no_autoflush", 40'(res_valid), 40'd0);
      exp_word(32'h00333231, 3'd3);
      do_flush();
      tick(3);
      chk("manual_flush_after_idle", 40'(rq.size()), 40'd0);
`endif

      tick(4);
      chk("weight_queue_drained", 40'(wq.size()), 40'd0);
      chk("line_queue_drained", 40'(lq.size()), 40'd0);
      chk("gap_queue_drained", 40'(gq.size()), 40'd0);
      chk("result_queue_drained", 40'(rq.size()), 40'd0);
      chk("gap_rx_quiet", 40'({g_res_valid, g_overflow, g_res_count, g_res_data}), 40'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
